guess_engine: RTL and testbench
===============================

# guess_engine

Parametrised guessing-game core for the PS/2 + seven-segment lab platform. It replaces the fixed two-digit judge with an N-digit decimal version that adds a try budget, a lose outcome, backspace editing, an out-of-range flag and a parametrised win/lose hold time. It sits between the keyboard decoder and the display selector. The key decoder maps scan codes to `key_code`, and the outputs drive the BCD display mux and the LED bar.

## Interface
Parameters:
- `DIGITS`, default 2: decimal digits per guess and bound. Legal range is 1–4.
- `MAX_TRIES`, default 7: wrong in-range guesses allowed per round. Legal range is 1–15.
- `HOLD_CYCLES`, default 33554432: number of `clk` cycles the WIN or LOSE state is held before returning to IDLE. Minimum is 1.

Ports:
- `clk`  in  1: system clock. All state updates on its rising edge.
- `rst`  in  1: reset. Asynchronous and active-low (0 = reset).
- `start`  in  1: debounced level. Its rising edge starts a round.
- `secret`  in  4*DIGITS: packed BCD secret, most significant digit in the top nibble. Every nibble is ≤ 9.
- `key_valid`  in  1: one-cycle pulse qualifying `key_code`.
- `key_code`  in  4: 0–9 = digit, 10 = enter, 11 = backspace. Any other value is ignored.
- `state`  out  3: 0 IDLE, 1 SHOW, 2 INPUT, 3 JUDGE, 4 WIN, 5 LOSE.
- `low_bcd`  out  4*DIGITS: current lower bound (exclusive), BCD.
- `high_bcd`  out  4*DIGITS: current upper bound (exclusive), BCD.
- `guess_bcd`  out  4*DIGITS: guess being typed, right-aligned, leading zeros.
- `digit_count`  out  3: number of digits typed so far, 0 to DIGITS.
- `tries_left`  out  4: remaining try budget.
- `oor`  out  1: one-cycle pulse when a judged guess lies outside (low, high).
- `win`  out  1: high while `state` = WIN.
- `lose`  out  1: high while `state` = LOSE.

## Operation
- **Reset values.** `state` = IDLE, `low_bcd` = 0, `high_bcd` = all nines (`ALL9`). `guess_bcd` = 0, `digit_count` = 0, `tries_left` = MAX_TRIES. `oor`, `win` and `lose` are 0. The hold counter and the secret latch are 0. Internal `start` history register is 0.
- **Registered outputs.** All outputs are registers; there are no combinational paths from inputs to outputs.
- **Start edge.** `start_rise` = `start` AND NOT `start_q`, where `start_q` is `start` registered every cycle.
- **IDLE.** On `start_rise`: latch `secret`, load `low` = 0, `high` = ALL9, `tries_left` = MAX_TRIES, clear guess and count, then go to SHOW. Keys are ignored. If `start_rise` and `key_valid` arrive in the same cycle, start wins and the key is dropped.
- **SHOW.** A digit key loads `guess` = digit in the low nibble, sets `count` = 1 and goes to INPUT. Enter, backspace and other codes are ignored.
- **INPUT, digit key.**
  - If `count` < DIGITS: `guess` = {guess shifted left one nibble, digit}, then increment `count`.
  - If `count` = DIGITS: the key is ignored. There is no wrap or overwrite.
- **INPUT, backspace.** Shift `guess` right one nibble (zero fill) and decrement `count`. If `count` reaches 0, return to SHOW.
- **INPUT, enter.** Go to JUDGE (`count` ≥ 1 always holds in INPUT).
- **Comparison.** Packed-BCD unsigned comparison equals numeric comparison, so no binary conversion is used.
- **JUDGE** lasts exactly one cycle. Priority order:
  1. `guess` = `secret`: set `low` = `high` = `secret` and go to WIN.
  2. `guess` ≤ `low` or `guess` ≥ `high`: pulse `oor`. Bounds and tries are unchanged. Go to SHOW.
  3. Otherwise, if `guess` < `secret` set `low` = `guess`, else set `high` = `guess`. Decrement `tries_left`. If the decremented value is 0 go to LOSE, else go to SHOW.
- **Clearing the guess.** On every exit from JUDGE, `guess` and `count` are cleared.
- **WIN / LOSE.** The hold counter clears on entry and increments every cycle. After HOLD_CYCLES cycles in the state, go to IDLE. `start` and keys are ignored.
- **Ignored inputs.** `start_rise` outside IDLE is ignored. A mid-round change on `secret` has no effect, because it is latched at start.
- **Reset assertion** in any state forces the reset values immediately, regardless of `clk`.

## Timing
- **Start.** `start` rises and is sampled at edge t. `state` = SHOW and the bounds are loaded after edge t, so `start` must have been low at edge t−1.
- **Key latency.** A key with `key_valid` at edge t is reflected in `guess_bcd`, `digit_count` and `state` after edge t.
- **Judge latency.** Enter at edge t gives `state` = JUDGE after t. The verdict state, updated bounds and tries appear after t+1. `oor` is high for exactly the cycle after t+1.
- **Hold length.** WIN or LOSE occupies exactly HOLD_CYCLES cycles, after which `state` = IDLE.
- **Flags.** `win` and `lose` change in the same cycle as `state`.
- **Throughput.** Back-to-back `key_valid` pulses on consecutive cycles are each processed. A key arriving during JUDGE is ignored.

## Test plan
- **Guess sequence.** DIGITS=2, MAX_TRIES=7, HOLD_CYCLES=4, secret=0x42, rise `start`, type 5,0,enter:
  - `high_bcd`=0x50 and `tries_left`=6 two cycles after enter.
  - Then type 3,0,enter: `low_bcd`=0x30.
  - Then type 4,2,enter: WIN, with `low`=`high`=0x42.
  - IDLE after 4 cycles.
- **Input editing.** Type 1,2,3: `guess_bcd`=0x12 and `digit_count`=2 (third digit ignored). Then backspace, backspace: `state` returns to SHOW with `guess_bcd`=0.
- **Out of range.** After `high`=0x50, guess 60 → `oor` pulse for 1 cycle, `tries_left` unchanged, bounds unchanged.
- **Lose.** MAX_TRIES=2, secret=0x10; guesses 50 then 20 → LOSE with `tries_left`=0 and `lose`=1 for HOLD_CYCLES cycles.
- **Start/key collisions.** In IDLE, `start_rise` and `key_valid` (digit 7) in the same cycle → SHOW with `digit_count`=0. `start` toggled during INPUT → no effect.
- **Reset mid-judge.** Assert `rst`=0 while in JUDGE → all outputs at their reset values before the next edge. With DIGITS=3, secret=0x999, guess 999 → WIN.

Source files
------------

// File: rtl/guess_engine.sv
// guess_engine: N-digit decimal guessing-game core. Tracks an exclusive
// (low, high) window around a latched secret, collects typed guesses with
// backspace editing, judges them against a try budget and holds the win or
// lose verdict for a fixed number of cycles before returning to idle.
// Guesses and bounds stay packed BCD throughout. An unsigned compare of
// packed BCD gives the same order as the numeric values, so no binary
// conversion is needed.
module guess_engine #(
    parameter int DIGITS      = 2,
    parameter int MAX_TRIES   = 7,
    parameter int HOLD_CYCLES = 33554432
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   secret,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic [2:0]            state,
    output logic [4*DIGITS-1:0]   low_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [4*DIGITS-1:0]   guess_bcd,
    output logic [2:0]            digit_count,
    output logic [3:0]            tries_left,
    output logic                  oor,
    output logic                  win,
    output logic                  lose
);

    localparam int W  = 4 * DIGITS;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [W-1:0]  ALL9      = {DIGITS{4'h9}};
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    CNT_MAX   = 3'(DIGITS);
    localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [3:0]    KEY_ENTER = 4'd10;
    localparam logic [3:0]    KEY_BKSP  = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHOW  = 3'd1,
        S_INPUT = 3'd2,
        S_JUDGE = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    state_t         st;
    logic           start_q;
    logic [W-1:0]   secret_q;
    logic [HW-1:0]  hold_cnt;

    logic           start_rise;
    logic           is_digit;
    logic [W-1:0]   guess_shl;
    logic [W-1:0]   guess_shr;

    assign state      = st;
    assign start_rise = start & ~start_q;
    assign is_digit   = (key_code <= 4'd9);

    // Nibble-shift helpers; a one-digit guess has nothing to shift through
    generate
        if (DIGITS == 1) begin : g_one_digit
            assign guess_shl = key_code;
            assign guess_shr = '0;
        end else begin : g_multi_digit
            assign guess_shl = {guess_bcd[W-5:0], key_code};
            assign guess_shr = {4'h0, guess_bcd[W-1:4]};
        end
    endgenerate

    // Round controller: every output is updated here as a register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= S_IDLE;
            start_q     <= 1'b0;
            secret_q    <= '0;
            hold_cnt    <= '0;
            low_bcd     <= '0;
            high_bcd    <= ALL9;
            guess_bcd   <= '0;
            digit_count <= '0;
            tries_left  <= TRIES_INIT;
            oor         <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            start_q <= start;
            oor     <= 1'b0;
            case (st)
                S_IDLE: begin
                    // A key coinciding with the start edge is dropped
                    if (start_rise) begin
                        secret_q    <= secret;
                        low_bcd     <= '0;
                        high_bcd    <= ALL9;
                        tries_left  <= TRIES_INIT;
                        guess_bcd   <= '0;
                        digit_count <= '0;
                        st          <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (key_valid && is_digit) begin
                        guess_bcd   <= W'(key_code);
                        digit_count <= 3'd1;
                        st          <= S_INPUT;
                    end
                end
                S_INPUT: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            // A full guess refuses further digits
                            if (digit_count < CNT_MAX) begin
                                guess_bcd   <= guess_shl;
                                digit_count <= digit_count + 3'd1;
                            end
                        end else if (key_code == KEY_BKSP) begin
                            guess_bcd   <= guess_shr;
                            digit_count <= digit_count - 3'd1;
                            if (digit_count == 3'd1) begin
                                st <= S_SHOW;
                            end
                        end else if (key_code == KEY_ENTER) begin
                            st <= S_JUDGE;
                        end
                    end
                end
                S_JUDGE: begin
                    guess_bcd   <= '0;
                    digit_count <= '0;
                    if (guess_bcd == secret_q) begin
                        low_bcd  <= secret_q;
                        high_bcd <= secret_q;
                        hold_cnt <= '0;
                        win      <= 1'b1;
                        st       <= S_WIN;
                    end else if (guess_bcd <= low_bcd || guess_bcd >= high_bcd) begin
                        // Outside the window: flag it, costs no try
                        oor <= 1'b1;
                        st  <= S_SHOW;
                    end else begin
                        if (guess_bcd < secret_q) begin
                            low_bcd <= guess_bcd;
                        end else begin
                            high_bcd <= guess_bcd;
                        end
                        tries_left <= tries_left - 4'd1;
                        if (tries_left == 4'd1) begin
                            hold_cnt <= '0;
                            lose     <= 1'b1;
                            st       <= S_LOSE;
                        end else begin
                            st <= S_SHOW;
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    // Counter counts cycles already spent in the verdict state
                    if (hold_cnt == HOLD_LAST) begin
                        win  <= 1'b0;
                        lose <= 1'b0;
                        st   <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_engine.sv
// tb_guess_engine: directed checks of guess_engine. Three instances cover
// the main round (2 digits, 7 tries), the lose path (2 tries) and a
// 3-digit round with an asynchronous reset taken in JUDGE.
module tb_guess_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus, routed to one instance at a time
    int         sel = 0;
    logic       start_v = 1'b0;
    logic       kv = 1'b0;
    logic [3:0] code = 4'd0;

    logic [7:0]  secret_a = 8'h42;
    logic [7:0]  secret_b = 8'h10;
    logic [11:0] secret_c = 12'h999;

    logic a_start, b_start, c_start, a_kv, b_kv, c_kv;
    assign a_start = start_v && (sel == 0);
    assign b_start = start_v && (sel == 1);
    assign c_start = start_v && (sel == 2);
    assign a_kv    = kv && (sel == 0);
    assign b_kv    = kv && (sel == 1);
    assign c_kv    = kv && (sel == 2);

    logic [2:0]  a_state, b_state, c_state;
    logic [7:0]  a_low, a_high, a_guess, b_low, b_high, b_guess;
    logic [11:0] c_low, c_high, c_guess;
    logic [2:0]  a_cnt, b_cnt, c_cnt;
    logic [3:0]  a_tries, b_tries, c_tries;
    logic        a_oor, a_win, a_lose, b_oor, b_win, b_lose, c_oor, c_win, c_lose;

    guess_engine #(.DIGITS(2), .MAX_TRIES(7), .HOLD_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .secret(secret_a),
        .key_valid(a_kv), .key_code(code), .state(a_state),
        .low_bcd(a_low), .high_bcd(a_high), .guess_bcd(a_guess),
        .digit_count(a_cnt), .tries_left(a_tries), .oor(a_oor),
        .win(a_win), .lose(a_lose)
    );

    guess_engine #(.DIGITS(2), .MAX_TRIES(2), .HOLD_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .secret(secret_b),
        .key_valid(b_kv), .key_code(code), .state(b_state),
        .low_bcd(b_low), .high_bcd(b_high), .guess_bcd(b_guess),
        .digit_count(b_cnt), .tries_left(b_tries), .oor(b_oor),
        .win(b_win), .lose(b_lose)
    );

    guess_engine #(.DIGITS(3), .MAX_TRIES(7), .HOLD_CYCLES(4)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .secret(secret_c),
        .key_valid(c_kv), .key_code(code), .state(c_state),
        .low_bcd(c_low), .high_bcd(c_high), .guess_bcd(c_guess),
        .digit_count(c_cnt), .tries_left(c_tries), .oor(c_oor),
        .win(c_win), .lose(c_lose)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        kv   = 1'b1;
        code = k;
        tick();
        kv   = 1'b0;
    endtask

    typedef struct {
        logic       st;
        logic       kv;
        logic [3:0] code;
        logic [2:0] e_state;
        logic [7:0] e_guess;
        logic [2:0] e_cnt;
        logic [3:0] e_tries;
        logic [7:0] e_low;
        logic [7:0] e_high;
        logic       e_oor;
        logic       e_win;
    } vec_t;

    vec_t vt[31];

    function automatic vec_t mk(input logic st, input logic k_v, input logic [3:0] k,
                                input logic [2:0] s, input logic [7:0] g, input logic [2:0] c,
                                input logic [3:0] t, input logic [7:0] lo, input logic [7:0] hi,
                                input logic o, input logic w);
        vec_t v;
        v.st = st; v.kv = k_v; v.code = k; v.e_state = s; v.e_guess = g; v.e_cnt = c;
        v.e_tries = t; v.e_low = lo; v.e_high = hi; v.e_oor = o; v.e_win = w;
        return v;
    endfunction

    initial begin
        // Main round on instance A: secret 42, window narrows 50 -> 30..50 -> win
        vt[0]  = mk(1, 0, 0,  1, 8'h00, 0, 7, 8'h00, 8'h99, 0, 0);
        vt[1]  = mk(0, 1, 5,  2, 8'h05, 1, 7, 8'h00, 8'h99, 0, 0);
        vt[2]  = mk(0, 1, 0,  2, 8'h50, 2, 7, 8'h00, 8'h99, 0, 0);
        vt[3]  = mk(0, 1, 10, 3, 8'h50, 2, 7, 8'h00, 8'h99, 0, 0);
        vt[4]  = mk(0, 0, 0,  1, 8'h00, 0, 6, 8'h00, 8'h50, 0, 0);
        vt[5]  = mk(0, 1, 1,  2, 8'h01, 1, 6, 8'h00, 8'h50, 0, 0);
        vt[6]  = mk(0, 1, 2,  2, 8'h12, 2, 6, 8'h00, 8'h50, 0, 0);
        vt[7]  = mk(0, 1, 3,  2, 8'h12, 2, 6, 8'h00, 8'h50, 0, 0);
        vt[8]  = mk(0, 1, 11, 2, 8'h01, 1, 6, 8'h00, 8'h50, 0, 0);
        vt[9]  = mk(0, 1, 11, 1, 8'h00, 0, 6, 8'h00, 8'h50, 0, 0);
        vt[10] = mk(0, 1, 6,  2, 8'h06, 1, 6, 8'h00, 8'h50, 0, 0);
        vt[11] = mk(0, 1, 0,  2, 8'h60, 2, 6, 8'h00, 8'h50, 0, 0);
        vt[12] = mk(0, 1, 10, 3, 8'h60, 2, 6, 8'h00, 8'h50, 0, 0);
        vt[13] = mk(0, 0, 0,  1, 8'h00, 0, 6, 8'h00, 8'h50, 1, 0);
        vt[14] = mk(0, 0, 0,  1, 8'h00, 0, 6, 8'h00, 8'h50, 0, 0);
        vt[15] = mk(0, 1, 10, 1, 8'h00, 0, 6, 8'h00, 8'h50, 0, 0);
        vt[16] = mk(0, 1, 3,  2, 8'h03, 1, 6, 8'h00, 8'h50, 0, 0);
        vt[17] = mk(0, 1, 0,  2, 8'h30, 2, 6, 8'h00, 8'h50, 0, 0);
        vt[18] = mk(0, 1, 10, 3, 8'h30, 2, 6, 8'h00, 8'h50, 0, 0);
        vt[19] = mk(0, 0, 0,  1, 8'h00, 0, 5, 8'h30, 8'h50, 0, 0);
        vt[20] = mk(0, 1, 4,  2, 8'h04, 1, 5, 8'h30, 8'h50, 0, 0);
        vt[21] = mk(0, 1, 2,  2, 8'h42, 2, 5, 8'h30, 8'h50, 0, 0);
        vt[22] = mk(1, 0, 0,  2, 8'h42, 2, 5, 8'h30, 8'h50, 0, 0);
        vt[23] = mk(0, 1, 10, 3, 8'h42, 2, 5, 8'h30, 8'h50, 0, 0);
        vt[24] = mk(0, 1, 9,  4, 8'h00, 0, 5, 8'h42, 8'h42, 0, 1);
        vt[25] = mk(0, 1, 7,  4, 8'h00, 0, 5, 8'h42, 8'h42, 0, 1);
        vt[26] = mk(1, 0, 0,  4, 8'h00, 0, 5, 8'h42, 8'h42, 0, 1);
        vt[27] = mk(1, 0, 0,  4, 8'h00, 0, 5, 8'h42, 8'h42, 0, 1);
        vt[28] = mk(0, 0, 0,  0, 8'h00, 0, 5, 8'h42, 8'h42, 0, 0);
        vt[29] = mk(1, 1, 7,  1, 8'h00, 0, 7, 8'h00, 8'h99, 0, 0);
        vt[30] = mk(0, 0, 0,  1, 8'h00, 0, 7, 8'h00, 8'h99, 0, 0);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(a_state), 32'd0);
        chk("reset low", 32'(a_low), 32'h00);
        chk("reset high", 32'(a_high), 32'h99);
        chk("reset guess", 32'(a_guess), 32'h00);
        chk("reset count", 32'(a_cnt), 32'd0);
        chk("reset tries", 32'(a_tries), 32'd7);
        chk("reset flags", {29'd0, a_oor, a_win, a_lose}, 32'd0);
        chk("reset high 3dig", 32'(c_high), 32'h999);
        #3 rst = 1'b1;
        tick();

        for (int i = 0; i < 31; i++) begin
            start_v = vt[i].st;
            kv      = vt[i].kv;
            code    = vt[i].code;
            tick();
            kv = 1'b0;
            $display("row %0d: st=%0d key=%0d/%0d -> state=%0d guess=%h cnt=%0d tries=%0d low=%h high=%h oor=%0d win=%0d",
                     i, vt[i].st, vt[i].kv, vt[i].code, a_state, a_guess, a_cnt, a_tries, a_low, a_high, a_oor, a_win);
            chk($sformatf("row%0d state", i), 32'(a_state), 32'(vt[i].e_state));
            chk($sformatf("row%0d guess", i), 32'(a_guess), 32'(vt[i].e_guess));
            chk($sformatf("row%0d count", i), 32'(a_cnt), 32'(vt[i].e_cnt));
            chk($sformatf("row%0d tries", i), 32'(a_tries), 32'(vt[i].e_tries));
            chk($sformatf("row%0d low", i), 32'(a_low), 32'(vt[i].e_low));
            chk($sformatf("row%0d high", i), 32'(a_high), 32'(vt[i].e_high));
            chk($sformatf("row%0d oor", i), 32'(a_oor), 32'(vt[i].e_oor));
            chk($sformatf("row%0d win", i), 32'(a_win), 32'(vt[i].e_win));
            chk($sformatf("row%0d lose", i), 32'(a_lose), 32'd0);
        end
        start_v = 1'b0;
        tick();

        // Lose path on instance B: secret latched at start, later changes ignored
        sel = 1;
        tick();
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        chk("B start state", 32'(b_state), 32'd1);
        secret_b = 8'h55;
        press(4'd5); press(4'd0); press(4'd10);
        tick();
        $display("B guess 50: state=%0d tries=%0d low=%h high=%h", b_state, b_tries, b_low, b_high);
        chk("B g50 high", 32'(b_high), 32'h50);
        chk("B g50 low", 32'(b_low), 32'h00);
        chk("B g50 tries", 32'(b_tries), 32'd1);
        chk("B g50 state", 32'(b_state), 32'd1);
        press(4'd2); press(4'd0); press(4'd10);
        tick();
        $display("B guess 20: state=%0d tries=%0d high=%h lose=%0d", b_state, b_tries, b_high, b_lose);
        chk("B lose tries", 32'(b_tries), 32'd0);
        chk("B lose high", 32'(b_high), 32'h20);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("B hold%0d state", k), 32'(b_state), 32'd5);
            chk($sformatf("B hold%0d lose", k), 32'(b_lose), 32'd1);
            tick();
        end
        chk("B after hold state", 32'(b_state), 32'd0);
        chk("B after hold lose", 32'(b_lose), 32'd0);

        // Instance C: 3-digit win where the guess equals the all-nines bound
        sel = 2;
        tick();
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        press(4'd9); press(4'd9); press(4'd9);
        chk("C guess 999", 32'(c_guess), 32'h999);
        chk("C count 3", 32'(c_cnt), 32'd3);
        press(4'd4);
        chk("C full guess", 32'(c_guess), 32'h999);
        press(4'd10);
        tick();
        $display("C guess 999: state=%0d low=%h high=%h win=%0d", c_state, c_low, c_high, c_win);
        chk("C win state", 32'(c_state), 32'd4);
        chk("C win flag", 32'(c_win), 32'd1);
        chk("C win low", 32'(c_low), 32'h999);
        chk("C win high", 32'(c_high), 32'h999);
        repeat (4) tick();
        chk("C idle state", 32'(c_state), 32'd0);

        // Asynchronous reset taken while JUDGE is active
        start_v = 1'b1;
        tick();
        start_v = 1'b0;
        press(4'd5);
        press(4'd10);
        chk("C judge state", 32'(c_state), 32'd3);
        #2 rst = 1'b0;
        #1;
        $display("C reset in judge: state=%0d guess=%h cnt=%0d tries=%0d low=%h high=%h", c_state, c_guess, c_cnt, c_tries, c_low, c_high);
        chk("C rst state", 32'(c_state), 32'd0);
        chk("C rst guess", 32'(c_guess), 32'h000);
        chk("C rst count", 32'(c_cnt), 32'd0);
        chk("C rst tries", 32'(c_tries), 32'd7);
        chk("C rst low", 32'(c_low), 32'h000);
        chk("C rst high", 32'(c_high), 32'h999);
        chk("C rst flags", {29'd0, c_oor, c_win, c_lose}, 32'd0);
        chk("A rst high", 32'(a_high), 32'h99);
        #2 rst = 1'b1;
        tick();
        chk("C after rst state", 32'(c_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
